// File: rtl/sram_bus_arbiter.sv
// Two-master (fetch/data) arbiter driving BaseRAM and ExtRAM asynchronous SRAMs.
// One registered-timing transaction at a time; completion is signalled by a one-cycle done pulse.
module sram_bus_arbiter #(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_done,

    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,

    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,

    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n
);

    localparam logic [2:0] RD_LAST = 3'(RD_CYCLES - 1);
    localparam logic [2:0] WR_LAST = 3'(WR_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD, WS, WP, WH, DN} state_t;

    state_t           state_reg;
    logic [2:0]       cnt_reg;
    logic             grant_inst_reg;
    logic             sel_ext_reg;
    logic             rr_data_reg;
    logic [31:0]      wdata_reg;
    logic [31:0]      inst_rdata_reg;
    logic [31:0]      data_rdata_reg;
    logic             inst_done_reg;
    logic             data_done_reg;

    // Per-RAM pin registers, index 0 = BaseRAM, 1 = ExtRAM.
    logic [1:0]       ce_n_reg;
    logic [1:0]       oe_n_reg;
    logic [1:0]       we_n_reg;
    logic [1:0]       drive_reg;
    logic [1:0][19:0] addr_reg;
    logic [1:0][3:0]  be_n_reg;

    logic             grant_valid;
    logic             grant_inst;
    logic [31:0]      g_addr;
    logic [3:0]       g_we;
    logic             g_base;
    logic             g_ext;
    logic             g_mapped;
    logic [31:0]      ram_rdata;
    logic             unused_addr_bits;

    always_comb begin
        grant_inst = inst_req;
        if (inst_req && data_req) begin
            grant_inst = ~rr_data_reg;
        end
        g_addr = grant_inst ? inst_addr : data_addr;
        g_we   = grant_inst ? 4'h0 : data_we;
    end

    assign grant_valid      = inst_req | data_req;
    assign g_base           = (g_addr[31:22] == 10'b10_0000_0000);
    assign g_ext            = (g_addr[31:22] == 10'b10_0000_0001);
    assign g_mapped         = g_base | g_ext;
    assign unused_addr_bits = ^g_addr[1:0];
    assign ram_rdata        = sel_ext_reg ? ext_ram_data : base_ram_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            grant_inst_reg <= 1'b0;
            sel_ext_reg    <= 1'b0;
            rr_data_reg    <= 1'b1;
            wdata_reg      <= '0;
            inst_rdata_reg <= '0;
            data_rdata_reg <= '0;
            inst_done_reg  <= 1'b0;
            data_done_reg  <= 1'b0;
            ce_n_reg       <= 2'b11;
            oe_n_reg       <= 2'b11;
            we_n_reg       <= 2'b11;
            drive_reg      <= 2'b00;
            addr_reg       <= '0;
            be_n_reg       <= '1;
        end else begin
            inst_done_reg <= 1'b0;
            data_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        grant_inst_reg <= grant_inst;
                        sel_ext_reg    <= g_ext;
                        wdata_reg      <= data_wdata;
                        if (inst_req && data_req) begin
                            rr_data_reg <= ~rr_data_reg;
                        end
                        if (!g_mapped) begin
                            // Unmapped: complete immediately with zero data, no pin activity.
                            state_reg <= DN;
                            if (grant_inst) begin
                                inst_done_reg  <= 1'b1;
                                inst_rdata_reg <= '0;
                            end else begin
                                data_done_reg  <= 1'b1;
                                data_rdata_reg <= '0;
                            end
                        end else begin
                            ce_n_reg[g_ext] <= 1'b0;
                            addr_reg[g_ext] <= g_addr[21:2];
                            if (g_we == 4'h0) begin
                                state_reg       <= RD;
                                cnt_reg         <= RD_LAST;
                                oe_n_reg[g_ext] <= 1'b0;
                                be_n_reg[g_ext] <= 4'h0;
                            end else begin
                                state_reg        <= WS;
                                be_n_reg[g_ext]  <= ~g_we;
                                drive_reg[g_ext] <= 1'b1;
                            end
                        end
                    end
                end
                RD: begin
                    if (cnt_reg == 3'd0) begin
                        state_reg <= DN;
                        ce_n_reg  <= 2'b11;
                        oe_n_reg  <= 2'b11;
                        be_n_reg  <= '1;
                        if (grant_inst_reg) begin
                            inst_done_reg  <= 1'b1;
                            inst_rdata_reg <= ram_rdata;
                        end else begin
                            data_done_reg  <= 1'b1;
                            data_rdata_reg <= ram_rdata;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                WS: begin
                    state_reg             <= WP;
                    cnt_reg               <= WR_LAST;
                    we_n_reg[sel_ext_reg] <= 1'b0;
                end
                WP: begin
                    if (cnt_reg == 3'd0) begin
                        state_reg <= WH;
                        we_n_reg  <= 2'b11;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                WH: begin
                    // Only the data port can write; writes complete with zero data.
                    state_reg      <= DN;
                    ce_n_reg       <= 2'b11;
                    be_n_reg       <= '1;
                    drive_reg      <= 2'b00;
                    data_done_reg  <= 1'b1;
                    data_rdata_reg <= '0;
                end
                DN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign inst_rdata    = inst_rdata_reg;
    assign inst_done     = inst_done_reg;
    assign data_rdata    = data_rdata_reg;
    assign data_done     = data_done_reg;

    assign base_ram_data = drive_reg[0] ? wdata_reg : 32'bz;
    assign base_ram_addr = addr_reg[0];
    assign base_ram_be_n = be_n_reg[0];
    assign base_ram_ce_n = ce_n_reg[0];
    assign base_ram_oe_n = oe_n_reg[0];
    assign base_ram_we_n = we_n_reg[0];

    assign ext_ram_data  = drive_reg[1] ? wdata_reg : 32'bz;
    assign ext_ram_addr  = addr_reg[1];
    assign ext_ram_be_n  = be_n_reg[1];
    assign ext_ram_ce_n  = ce_n_reg[1];
    assign ext_ram_oe_n  = oe_n_reg[1];
    assign ext_ram_we_n  = we_n_reg[1];

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: two behavioural SRAMs on the main instance,
// plus RD_CYCLES=1 and 4 instances used only for fetch timing.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        data_req = 1'b0;
    logic [3:0]  data_we = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;

    wire  [31:0] inst_rdata, data_rdata;
    wire         inst_done, data_done;
    wire  [31:0] base_ram_data, ext_ram_data;
    wire  [19:0] base_ram_addr, ext_ram_addr;
    wire  [3:0]  base_ram_be_n, ext_ram_be_n;
    wire         base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
    wire         ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
    wire  [5:0]  strobes = {base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
                            ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n};

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] base_mem [256];
    logic [31:0] ext_mem  [256];
    logic [1:0]  sw_done;
    int          q_main[$];
    int          q_r1[$];
    int          q_r4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_bus_arbiter #(.RD_CYCLES(2), .WR_CYCLES(2)) u_dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_done(data_done),
        .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
        .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
        .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
        .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n)
    );

    // Behavioural SRAMs: drive on ce_n&oe_n low, write bytes on the rising edge of we_n.
    assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? base_mem[base_ram_addr[7:0]] : 32'bz;
    assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? ext_mem[ext_ram_addr[7:0]] : 32'bz;

    always @(posedge base_ram_we_n) begin
        if (!base_ram_ce_n) begin
            for (int b = 0; b < 4; b++)
                if (!base_ram_be_n[b]) base_mem[base_ram_addr[7:0]][b*8 +: 8] = base_ram_data[b*8 +: 8];
        end
    end

    always @(posedge ext_ram_we_n) begin
        if (!ext_ram_ce_n) begin
            for (int b = 0; b < 4; b++)
                if (!ext_ram_be_n[b]) ext_mem[ext_ram_addr[7:0]][b*8 +: 8] = ext_ram_data[b*8 +: 8];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pull
            pulldown pd_base (base_ram_data[gi]);
            pulldown pd_ext (ext_ram_data[gi]);
        end
        for (gi = 0; gi < 2; gi++) begin : g_sweep
            localparam int RDC = (gi == 0) ? 1 : 4;
            wire [31:0] b_data, e_data, i_rd, d_rd;
            wire [19:0] b_addr, e_addr;
            wire [3:0]  b_be, e_be;
            wire        b_ce, b_oe, b_we, e_ce, e_oe, e_we, d_done;
            sram_bus_arbiter #(.RD_CYCLES(RDC), .WR_CYCLES(2)) u_sw (
                .clk(clk), .resetn(resetn),
                .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(i_rd), .inst_done(sw_done[gi]),
                .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
                .data_rdata(d_rd), .data_done(d_done),
                .base_ram_data(b_data), .base_ram_addr(b_addr), .base_ram_be_n(b_be),
                .base_ram_ce_n(b_ce), .base_ram_oe_n(b_oe), .base_ram_we_n(b_we),
                .ext_ram_data(e_data), .ext_ram_addr(e_addr), .ext_ram_be_n(e_be),
                .ext_ram_ce_n(e_ce), .ext_ram_oe_n(e_oe), .ext_ram_we_n(e_we)
            );
        end
    endgenerate

    always @(negedge clk) begin
        if (inst_done)  q_main.push_back(cyc);
        if (sw_done[0]) q_r1.push_back(cyc);
        if (sw_done[1]) q_r4.push_back(cyc);
    end

    task automatic test_reset();
        #1 resetn = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h8000_0010;
        repeat (3) @(negedge clk);
        n_cmp++; if (strobes !== 6'h3F) begin n_bad++; $display("FAIL reset_strobes: got %b want 111111", strobes); end
        n_cmp++; if ({base_ram_be_n, ext_ram_be_n} !== 8'hFF) begin n_bad++; $display("FAIL reset_be_n: got %h want ff", {base_ram_be_n, ext_ram_be_n}); end
        n_cmp++; if ({base_ram_addr, ext_ram_addr} !== 40'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", {base_ram_addr, ext_ram_addr}); end
        n_cmp++; if ({base_ram_data, ext_ram_data} !== 64'h0) begin n_bad++; $display("FAIL reset_bus_released: got %h want 0 (pulled)", {base_ram_data, ext_ram_data}); end
        n_cmp++; if ({inst_done, data_done} !== 2'b00) begin n_bad++; $display("FAIL reset_done: got %b want 00", {inst_done, data_done}); end
        n_cmp++; if ({inst_rdata, data_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", {inst_rdata, data_rdata}); end
        $display("reset held with inst_req=1: strobes=%b", strobes);
    endtask

    task automatic test_fetch();
        resetn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++; if (strobes !== ((k <= 2) ? 6'b001111 : 6'b111111)) begin n_bad++; $display("FAIL fetch_strobes k=%0d: got %b", k, strobes); end
            n_cmp++; if ({inst_done, data_done} !== {(k == 3), 1'b0}) begin n_bad++; $display("FAIL fetch_done k=%0d: got %b", k, {inst_done, data_done}); end
            if (k == 1) begin
                n_cmp++; if ({base_ram_addr, base_ram_be_n} !== {20'h00004, 4'h0}) begin n_bad++; $display("FAIL fetch_addr: got %h/%b want 00004/0000", base_ram_addr, base_ram_be_n); end
            end
            if (k == 3) begin
                n_cmp++; if (inst_rdata !== 32'hB000_0404) begin n_bad++; $display("FAIL fetch_rdata: got %h want b0000404", inst_rdata); end
                $display("fetch 80000010 -> %h done at T+%0d", inst_rdata, k);
                inst_req = 1'b0;
            end
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        data_req = 1'b1; data_we = 4'b0011; data_addr = 32'h8040_0008; data_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 6; k++) begin
            logic exp_ce, exp_we;
            @(negedge clk);
            exp_ce = (k <= 4) ? 1'b0 : 1'b1;
            exp_we = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            n_cmp++; if (strobes !== {3'b111, exp_ce, 1'b1, exp_we}) begin n_bad++; $display("FAIL store_strobes k=%0d: got %b want %b", k, strobes, {3'b111, exp_ce, 1'b1, exp_we}); end
            n_cmp++; if (ext_ram_data !== ((k <= 4) ? 32'hDEAD_BEEF : 32'h0)) begin n_bad++; $display("FAIL store_bus k=%0d: got %h", k, ext_ram_data); end
            n_cmp++; if (ext_ram_be_n !== ((k <= 4) ? 4'b1100 : 4'b1111)) begin n_bad++; $display("FAIL store_be_n k=%0d: got %b", k, ext_ram_be_n); end
            n_cmp++; if ({inst_done, data_done} !== {1'b0, (k == 5)}) begin n_bad++; $display("FAIL store_done k=%0d: got %b", k, {inst_done, data_done}); end
            if (k == 1) begin
                n_cmp++; if (ext_ram_addr !== 20'h2) begin n_bad++; $display("FAIL store_addr: got %h want 00002", ext_ram_addr); end
            end
            if (k == 5) begin
                n_cmp++; if (data_rdata !== 32'h0) begin n_bad++; $display("FAIL store_rdata: got %h want 0", data_rdata); end
                $display("store 80400008 we=0011 wdata=deadbeef done at T+%0d", k);
                data_req = 1'b0;
            end
        end
        @(negedge clk);
        data_req = 1'b1; data_we = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++; if (data_done !== (k == 3)) begin n_bad++; $display("FAIL readback_done k=%0d: got %b", k, data_done); end
            if (k == 1) begin
                n_cmp++; if ({ext_ram_be_n, ext_ram_oe_n} !== 5'b0) begin n_bad++; $display("FAIL readback_pins: got %b want 00000", {ext_ram_be_n, ext_ram_oe_n}); end
            end
            if (k == 3) begin
                n_cmp++; if (data_rdata !== 32'hE000_BEEF) begin n_bad++; $display("FAIL readback_rdata: got %h want e000beef", data_rdata); end
                $display("load 80400008 -> %h", data_rdata);
                data_req = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h8000_0020;
        data_req = 1'b1; data_we = 4'h0; data_addr = 32'h8040_0010;
        for (int k = 1; k <= 16; k++) begin
            logic exp_id, exp_dd;
            @(negedge clk);
            exp_id = (k == 7 || k == 15);
            exp_dd = (k == 3 || k == 11);
            n_cmp++; if ({inst_done, data_done} !== {exp_id, exp_dd}) begin n_bad++; $display("FAIL rr_done k=%0d: got %b want %b", k, {inst_done, data_done}, {exp_id, exp_dd}); end
            if (exp_dd) begin
                n_cmp++; if (data_rdata !== 32'hE000_0004) begin n_bad++; $display("FAIL rr_data_rdata k=%0d: got %h want e0000004", k, data_rdata); end
                $display("rr grant data -> %h done at T+%0d", data_rdata, k);
            end
            if (exp_id) begin
                n_cmp++; if (inst_rdata !== 32'hB000_0808) begin n_bad++; $display("FAIL rr_inst_rdata k=%0d: got %h want b0000808", k, inst_rdata); end
                $display("rr grant inst -> %h done at T+%0d", inst_rdata, k);
            end
            if (k == 1) begin
                n_cmp++; if ({strobes, ext_ram_addr} !== {6'b111001, 20'h4}) begin n_bad++; $display("FAIL rr_first_grant: got %b/%h want 111001/00004", strobes, ext_ram_addr); end
            end
            if (k == 5) begin
                n_cmp++; if ({strobes, base_ram_addr} !== {6'b001111, 20'h8}) begin n_bad++; $display("FAIL rr_second_grant: got %b/%h want 001111/00008", strobes, base_ram_addr); end
            end
            if (k == 15) begin
                inst_req = 1'b0; data_req = 1'b0;
            end
        end
    endtask

    task automatic test_unmapped();
        @(negedge clk);
        data_req = 1'b1; data_we = 4'h0; data_addr = 32'h1000_0000;
        @(negedge clk);
        n_cmp++; if ({data_done, data_rdata} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL unmapped_done: got %b/%h want 1/0", data_done, data_rdata); end
        n_cmp++; if (strobes !== 6'h3F) begin n_bad++; $display("FAIL unmapped_pins: got %b want 111111", strobes); end
        $display("load 10000000 (unmapped) -> %h", data_rdata);
        data_req = 1'b0;
        @(negedge clk);
        n_cmp++; if ({data_done, strobes} !== {1'b0, 6'h3F}) begin n_bad++; $display("FAIL unmapped_after: got %b", {data_done, strobes}); end
    endtask

    task automatic test_abort();
        @(negedge clk);
        data_req = 1'b1; data_we = 4'hF; data_addr = 32'h8000_0030; data_wdata = 32'h1234_5678;
        @(negedge clk);
        n_cmp++; if (strobes !== 6'b011111) begin n_bad++; $display("FAIL abort_ws: got %b want 011111", strobes); end
        @(negedge clk);
        n_cmp++; if (strobes !== 6'b010111) begin n_bad++; $display("FAIL abort_wp: got %b want 010111", strobes); end
        resetn = 1'b0; data_req = 1'b0;
        #1;
        n_cmp++; if ({strobes, base_ram_be_n} !== {6'h3F, 4'hF}) begin n_bad++; $display("FAIL abort_pins: got %b want 1111111111", {strobes, base_ram_be_n}); end
        n_cmp++; if (base_ram_data !== 32'h0) begin n_bad++; $display("FAIL abort_bus: got %h want 0 (released)", base_ram_data); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if ({inst_done, data_done} !== 2'b00) begin n_bad++; $display("FAIL abort_no_done k=%0d: got %b", k, {inst_done, data_done}); end
        end
        $display("store 80000030 aborted by reset in WP");
        resetn = 1'b1; data_req = 1'b1; data_we = 4'h0; data_addr = 32'h8040_0008;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++; if (data_done !== (k == 3)) begin n_bad++; $display("FAIL post_abort_done k=%0d: got %b", k, data_done); end
            if (k == 3) begin
                n_cmp++; if (data_rdata !== 32'hE000_BEEF) begin n_bad++; $display("FAIL post_abort_rdata: got %h want e000beef", data_rdata); end
                $display("load 80400008 after reset -> %h", data_rdata);
                data_req = 1'b0;
            end
        end
    endtask

    task automatic test_sweep();
        int t0;
        int e2[4] = '{3, 7, 11, 15};
        int e1[5] = '{2, 5, 8, 11, 14};
        int e4[3] = '{5, 11, 17};
        repeat (10) @(negedge clk);
        q_main.delete(); q_r1.delete(); q_r4.delete();
        inst_req = 1'b1; inst_addr = 32'h8000_0000;
        t0 = cyc;
        repeat (13) @(negedge clk);
        inst_req = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (q_main.size() != 4) begin n_bad++; $display("FAIL sweep_rd2_count: got %0d want 4", q_main.size()); end
        n_cmp++; if (q_r1.size() != 5) begin n_bad++; $display("FAIL sweep_rd1_count: got %0d want 5", q_r1.size()); end
        n_cmp++; if (q_r4.size() != 3) begin n_bad++; $display("FAIL sweep_rd4_count: got %0d want 3", q_r4.size()); end
        for (int i = 0; i < 4 && i < q_main.size(); i++) begin
            n_cmp++; if (q_main[i] - t0 != e2[i]) begin n_bad++; $display("FAIL sweep_rd2 #%0d: got T+%0d want T+%0d", i, q_main[i] - t0, e2[i]); end
        end
        for (int i = 0; i < 5 && i < q_r1.size(); i++) begin
            n_cmp++; if (q_r1[i] - t0 != e1[i]) begin n_bad++; $display("FAIL sweep_rd1 #%0d: got T+%0d want T+%0d", i, q_r1[i] - t0, e1[i]); end
            $display("rd1 fetch %0d done at T+%0d", i, q_r1[i] - t0);
        end
        for (int i = 0; i < 3 && i < q_r4.size(); i++) begin
            n_cmp++; if (q_r4[i] - t0 != e4[i]) begin n_bad++; $display("FAIL sweep_rd4 #%0d: got T+%0d want T+%0d", i, q_r4[i] - t0, e4[i]); end
            $display("rd4 fetch %0d done at T+%0d", i, q_r4[i] - t0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            base_mem[i] = 32'hB000_0000 | (i << 8) | i;
            ext_mem[i]  = 32'hE000_0000 | i;
        end
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_unmapped();
        test_abort();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Sits directly downstream of the CPU core's fetch and memory stages.
- Arbitrates instruction-fetch and data-access requests onto the board's two asynchronous SRAMs, BaseRAM and ExtRAM.
- Runs one multi-cycle SRAM transaction at a time through a registered timing FSM and returns read data with a one-cycle done pulse.
- Drives the tri-state 32-bit SRAM data buses.

Parameters:
- RD_CYCLES, 2: cycles the read strobes (ce_n/oe_n) are held before data is sampled; legal range 1..7.
- WR_CYCLES, 2: cycles the we_n pulse is held low; legal range 1..7.

Ports:
- clk  input  1  core clock; all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- inst_req  input  1  fetch request; held until inst_done.
- inst_addr  input  32  fetch byte address.
- inst_rdata  output  32  fetch data; valid while inst_done=1.
- inst_done  output  1  one-cycle completion pulse for fetch.
- data_req  input  1  data request; held until data_done.
- data_we  input  4  byte write enables; 0 = read.
- data_addr  input  32  data byte address.
- data_wdata  input  32  store data.
- data_rdata  output  32  load data; valid while data_done=1.
- data_done  output  1  one-cycle completion pulse for data.
- base_ram_data  inout  32  BaseRAM data bus.
- base_ram_addr  output  20  BaseRAM word address.
- base_ram_be_n  output  4  BaseRAM byte enables, active low.
- base_ram_ce_n / base_ram_oe_n / base_ram_we_n  output  1 each  BaseRAM chip select, read enable and write enable, active low.
- ext_ram_data  inout  32  ExtRAM data bus.
- ext_ram_addr  output  20  ExtRAM word address.
- ext_ram_be_n  output  4  ExtRAM byte enables, active low.
- ext_ram_ce_n / ext_ram_oe_n / ext_ram_we_n  output  1 each  ExtRAM chip select, read enable and write enable, active low.

Behaviour:
- Reset state (asynchronous, immediate, including mid-transaction):
  - All *_ce_n/*_oe_n/*_we_n = 1 and *_be_n = 4'hF.
  - Addresses 0; both data buses high-Z.
  - inst_done = data_done = 0; rdata outputs 0.
  - FSM in IDLE; the round-robin bit points to data.
  - An interrupted access is dropped and never completed.
- Address decode:
  - 0x8000_0000..0x803F_FFFF selects BaseRAM.
  - 0x8040_0000..0x807F_FFFF selects ExtRAM.
  - The word address is addr[21:2]; addr[1:0] is ignored.
  - Any other address is "unmapped": no SRAM pin activity, reads return 0, writes are discarded, and done is issued 1 cycle after acceptance.
- Arbitration, evaluated only in IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant alternates, starting with data after reset. The bit flips on each grant made while both are pending.
  - The request is latched at grant; later changes to the request inputs are ignored until done.
- All SRAM control, address and byte-enable outputs are registered.
- FSM states:
  - IDLE: nothing active. On grant, go to RD (read, or any inst request) or WS (data_we != 0), or DN if unmapped.
  - RD: selected RAM has ce_n=0, oe_n=0, be_n=0, addr driven. Held for RD_CYCLES cycles. On the edge ending the last RD cycle, the RAM data is captured into the rdata register. Then go to DN.
  - WS (write setup, 1 cycle): ce_n=0, we_n=1, be_n=~data_we, addr driven, data bus driven with data_wdata.
  - WP (write pulse, WR_CYCLES cycles): as WS but with we_n=0.
  - WH (write hold, 1 cycle): we_n=1, ce_n=0, data still driven. Then go to DN.
  - DN (1 cycle): all strobes deasserted, bus high-Z, the granted requester's done=1 with rdata valid (writes return 0). Then go to IDLE.
- The non-selected RAM stays fully idle throughout.
- A data bus is driven only in WS/WP/WH and only for the selected RAM. It is never driven in the same cycle as that RAM's oe_n=0.
- Read latency from the request-seen cycle T: pins active T+1..T+RD_CYCLES, done at T+RD_CYCLES+1.
- Write latency from T: done at T+WR_CYCLES+3.
- Back-to-back: a requester still asserting req in the DN cycle is treated as a new request in the following IDLE cycle. Minimum issue interval is therefore RD_CYCLES+2 cycles.
- inst_done and data_done are never both 1 in the same cycle.

Test Plan:
- Reset hold with inst_req=1 -> all strobes 1, both buses Z, no done. After release, a single fetch to 0x8000_0010 -> base_ram_addr=0x00004, ce_n/oe_n low for 2 cycles, inst_done at T+3 with inst_rdata = the BaseRAM model word.
- Data store to 0x8040_0008, we=4'b0011, wdata=0xDEADBEEF -> ext_ram_addr=2, be_n=4'b1100, we_n low exactly WR_CYCLES=2 cycles inside ce_n low, bus driven WS..WH, data_done at T+5. A read-back then returns 0x????BEEF bytes as modelled.
- inst_req and data_req both held continuously -> grants go data, inst, data, inst; done pulses never overlap; each requester's addresses are preserved.
- Read from unmapped 0x1000_0000 -> no ce_n activity on either RAM, data_done at T+1, data_rdata=0.
- resetn asserted during WP -> we_n and ce_n return to 1 and the bus goes Z in the same cycle; no done pulse; the next request after release completes normally.
- Sweep RD_CYCLES=1 and 4 -> read done at T+2 and T+5 respectively; back-to-back fetches issue every RD_CYCLES+2 cycles.
